// File: rtl/axi4_outstanding_tracker_if.sv
// -----------------------------------------------------------------------------
// axi4_outstanding_tracker_if
//
// Write-channel handshake bundle (AW, W, B) between an AXI4 write master and
// the outstanding-write tracker. Clock and reset stay outside the bundle.
//
// Parameters:
//   ID_WIDTH   width of aw_id / b_id
//   LEN_WIDTH  width of aw_len
//
// Modports:
//   master  drives AW/W requests and b_ready; observes ready/response signals
//   slave   the tracker side: drives aw_ready, w_ready, b_valid, b_id, b_resp
// -----------------------------------------------------------------------------
interface axi4_outstanding_tracker_if #(
   parameter int ID_WIDTH  = 4,
   parameter int LEN_WIDTH = 8
);
   // AW channel
   logic                 aw_valid;
   logic                 aw_ready;
   logic [ID_WIDTH-1:0]  aw_id;
   logic [LEN_WIDTH-1:0] aw_len;

   // W channel (data payload is not tracked, only the framing)
   logic                 w_valid;
   logic                 w_ready;
   logic                 w_last;

   // B channel
   logic                 b_valid;
   logic                 b_ready;
   logic [ID_WIDTH-1:0]  b_id;
   logic [1:0]           b_resp;

   modport master (
      output aw_valid, aw_id, aw_len,
      output w_valid, w_last,
      output b_ready,
      input  aw_ready, w_ready,
      input  b_valid, b_id, b_resp
   );

   modport slave (
      input  aw_valid, aw_id, aw_len,
      input  w_valid, w_last,
      input  b_ready,
      output aw_ready, w_ready,
      output b_valid, b_id, b_resp
   );
endinterface

// File: rtl/axi4_outstanding_tracker.sv
// -----------------------------------------------------------------------------
// axi4_outstanding_tracker
//
// Slave-side AXI4 write-transaction tracker. Every AW handshake allocates one
// slot of a DEPTH-entry circular table; W beats are attributed to slots in AW
// order; B responses are issued either strictly in AW order or out of order
// while still honouring same-ID ordering.
//
// Parameters:
//   ID_WIDTH   width of aw_id / b_id
//   LEN_WIDTH  width of aw_len (beats minus one)
//   DEPTH      maximum outstanding writes, power of two, >= 2
//
// Ports:
//   aclk               clock, rising edge
//   aresetn            synchronous active-low reset
//   cfg_out_of_order   0 = responses in AW order, 1 = out of order
//   bus                write-channel bundle (slave modport)
//   outstanding_count  number of occupied slots
//   wlast_err          one-cycle pulse when WLAST disagrees with aw_len
//
// Build option:
//   AXI4_OUTSTANDING_TRACKER_WLAST_CHECK_EN
//     defined   : beat counter per active write; a write ends on
//                 (beat == len) || w_last, a mismatch gives SLVERR and
//                 pulses wlast_err.
//     undefined : a write ends only on w_last; b_resp is always OKAY and
//                 wlast_err is tied low.
// -----------------------------------------------------------------------------
module axi4_outstanding_tracker #(
   parameter int ID_WIDTH  = 4,
   parameter int LEN_WIDTH = 8,
   parameter int DEPTH     = 16
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         cfg_out_of_order,
   axi4_outstanding_tracker_if.slave    bus,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding_count,
   output logic                         wlast_err
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH+1);
   localparam int NUM_IDS = 1 << ID_WIDTH;

   typedef logic [PTR_W-1:0] ptr_t;

   // Per-slot state flags
   logic [DEPTH-1:0]     occupied;
   logic [DEPTH-1:0]     complete;
   logic [DEPTH-1:0]     issued;
   logic [ID_WIDTH-1:0]  slot_id [DEPTH];

   // Circular pointers: allocate, oldest occupied, oldest awaiting data
   ptr_t                 tail;
   ptr_t                 head;
   ptr_t                 wptr;
   logic [CNT_W-1:0]     count_q;

   // B output register and the slot it belongs to
   logic                 b_valid_q;
   logic [ID_WIDTH-1:0]  b_id_q;
   ptr_t                 b_slot_q;

   logic                 aw_hs;
   logic                 w_hs;
   logic                 w_term;
   logic                 b_hs;
   logic                 load_en;
   logic                 head_adv;

   // Selection scan results
   logic                 sel_found;
   ptr_t                 sel_idx;
   ptr_t                 scan_idx;
   logic [NUM_IDS-1:0]   seen_id;
   logic                 order_blk;

   // --------------------------------------------------------------------------
   // Handshakes and ready signals (all readies come from registered state)
   // --------------------------------------------------------------------------
   assign bus.aw_ready = !occupied[tail];
   assign bus.w_ready  = occupied[wptr] && !complete[wptr];
   assign bus.b_valid  = b_valid_q;
   assign bus.b_id     = b_id_q;

   assign aw_hs   = bus.aw_valid && bus.aw_ready;
   assign w_hs    = bus.w_valid  && bus.w_ready;
   assign b_hs    = b_valid_q    && bus.b_ready;
   assign load_en = !b_valid_q   || bus.b_ready;

   assign outstanding_count = count_q;

   // Head steps over freed slots. The count term covers the case where the
   // table was full (head == tail) and the head slot itself was freed: the
   // remaining entries sit past head, so head must still move.
   assign head_adv = !occupied[head] && ((head != tail) || (count_q != '0));

   // --------------------------------------------------------------------------
   // Response selection. Scans all slots from head (oldest first).
   //   In order   : only the oldest not-yet-issued entry may go, once complete.
   //                Already-issued entries are skipped so the next response can
   //                be loaded in the same cycle the current one handshakes.
   //   Out of order: the oldest complete, unissued entry with no older
   //                occupied entry of the same ID.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no
      // path leaves it unassigned and no latch is inferred.
      sel_found = 1'b0;
      sel_idx   = '0;
      scan_idx  = '0;
      seen_id   = '0;
      order_blk = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head + ptr_t'(i);
         if (occupied[scan_idx]) begin
            if (!sel_found && !issued[scan_idx] && complete[scan_idx] &&
                (cfg_out_of_order ? !seen_id[slot_id[scan_idx]] : !order_blk)) begin
               sel_found = 1'b1;
               sel_idx   = scan_idx;
            end
            if (!issued[scan_idx]) begin
               order_blk = 1'b1;
            end
            seen_id[slot_id[scan_idx]] = 1'b1;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Slot flags, pointers, count and B register. The four per-slot writers
   // (allocate, complete, issue, free) can never address the same slot in one
   // cycle, since each requires a different flag state.
   // --------------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      // NOTE: state registers use non-blocking assignments so every read in
      // this block sees the pre-edge value regardless of statement order.
      if (!aresetn) begin
         occupied  <= '0;
         complete  <= '0;
         issued    <= '0;
         tail      <= '0;
         head      <= '0;
         wptr      <= '0;
         count_q   <= '0;
         b_valid_q <= 1'b0;
         b_id_q    <= '0;
         b_slot_q  <= '0;
      end else begin
         if (aw_hs) begin
            occupied[tail] <= 1'b1;
            complete[tail] <= 1'b0;
            issued[tail]   <= 1'b0;
            tail           <= tail + 1'b1;
         end

         if (w_term) begin
            complete[wptr] <= 1'b1;
            wptr           <= wptr + 1'b1;
         end

         if (load_en) begin
            b_valid_q <= sel_found;
            if (sel_found) begin
               b_id_q          <= slot_id[sel_idx];
               b_slot_q        <= sel_idx;
               issued[sel_idx] <= 1'b1;
            end
         end

         if (b_hs) begin
            occupied[b_slot_q] <= 1'b0;
         end

         if (head_adv) begin
            head <= head + 1'b1;
         end

         case ({aw_hs, b_hs})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: the payload table has no reset; it is only read for slots whose
   // occupied flag is set, and that flag is reset, so clearing the payload
   // would cost a reset net per bit for nothing.
   always_ff @(posedge aclk) begin
      if (aw_hs) begin
         slot_id[tail] <= bus.aw_id;
      end
   end

`ifdef AXI4_OUTSTANDING_TRACKER_WLAST_CHECK_EN
   // --------------------------------------------------------------------------
   // WLAST checking: beat counter for slot[wptr], per-slot error flag.
   // --------------------------------------------------------------------------
   logic [DEPTH-1:0]     err;
   logic [LEN_WIDTH-1:0] slot_len [DEPTH];
   logic [LEN_WIDTH-1:0] beat_q;
   logic                 beat_at_len;
   logic                 wlast_err_q;
   logic [1:0]           b_resp_q;

   assign beat_at_len = (beat_q == slot_len[wptr]);
   assign w_term      = w_hs && (beat_at_len || bus.w_last);
   assign wlast_err   = wlast_err_q;
   assign bus.b_resp  = b_resp_q;

   always_ff @(posedge aclk) begin
      if (aw_hs) begin
         slot_len[tail] <= bus.aw_len;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         err         <= '0;
         beat_q      <= '0;
         wlast_err_q <= 1'b0;
         b_resp_q    <= 2'b00;
      end else begin
         // A terminal beat is an error when the length and WLAST disagree.
         wlast_err_q <= w_term && (beat_at_len != bus.w_last);

         if (aw_hs) begin
            err[tail] <= 1'b0;
         end
         if (w_term) begin
            err[wptr] <= (beat_at_len != bus.w_last);
         end

         if (w_term) begin
            beat_q <= '0;
         end else if (w_hs) begin
            beat_q <= beat_q + 1'b1;
         end

         if (load_en && sel_found) begin
            b_resp_q <= err[sel_idx] ? 2'b10 : 2'b00;
         end
      end
   end
`else
   // Without the check a write ends on WLAST alone and always answers OKAY.
   logic [LEN_WIDTH-1:0] unused_aw_len;

   assign unused_aw_len = bus.aw_len;
   assign w_term        = w_hs && bus.w_last;
   assign wlast_err     = 1'b0;
   assign bus.b_resp    = 2'b00;
`endif

endmodule

// File: tb/tb_axi4_outstanding_tracker.sv
// -----------------------------------------------------------------------------
// tb_axi4_outstanding_tracker
//
// Directed bench for axi4_outstanding_tracker. Inputs change just after the
// falling edge; outputs are sampled at the falling edge, half a cycle away
// from the active rising edge.
// -----------------------------------------------------------------------------
module tb_axi4_outstanding_tracker;

   localparam int ID_WIDTH  = 4;
   localparam int LEN_WIDTH = 8;
   localparam int DEPTH     = 16;
   localparam int BOUND     = 100;

`ifdef AXI4_OUTSTANDING_TRACKER_WLAST_CHECK_EN
   localparam logic [1:0] ERR_RESP  = 2'b10;
   localparam logic       ERR_PULSE = 1'b1;
`else
   localparam logic [1:0] ERR_RESP  = 2'b00;
   localparam logic       ERR_PULSE = 1'b0;
`endif

   logic                        aclk = 1'b0;
   logic                        aresetn = 1'b0;
   logic                        cfg_out_of_order = 1'b0;
   logic [$clog2(DEPTH+1)-1:0]  outstanding_count;
   logic                        wlast_err;

   int errors = 0;
   int checks = 0;

   axi4_outstanding_tracker_if #(.ID_WIDTH(ID_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

   axi4_outstanding_tracker #(
      .ID_WIDTH  (ID_WIDTH),
      .LEN_WIDTH (LEN_WIDTH),
      .DEPTH     (DEPTH)
   ) dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .cfg_out_of_order  (cfg_out_of_order),
      .bus               (bus),
      .outstanding_count (outstanding_count),
      .wlast_err         (wlast_err)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge aclk);
   endtask

   // AW request; returns at the falling edge after the handshake.
   task automatic send_aw(input logic [ID_WIDTH-1:0] id, input logic [LEN_WIDTH-1:0] len);
      int n = 0;
      bus.aw_valid = 1'b1;
      bus.aw_id    = id;
      bus.aw_len   = len;
      while (!bus.aw_ready && n < BOUND) begin
         tick();
         n++;
      end
      check("aw_accept", 32'(bus.aw_ready), 32'd1);
      tick();
      bus.aw_valid = 1'b0;
   endtask

   // One W beat; returns at the falling edge after the handshake.
   task automatic send_w(input logic last);
      int n = 0;
      bus.w_valid = 1'b1;
      bus.w_last  = last;
      while (!bus.w_ready && n < BOUND) begin
         tick();
         n++;
      end
      check("w_accept", 32'(bus.w_ready), 32'd1);
      tick();
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
   endtask

   // Wait for a response, check it, then accept it.
   task automatic take_b(input string tag, input logic [ID_WIDTH-1:0] exp_id,
                         input logic [1:0] exp_resp);
      int n = 0;
      while (!bus.b_valid && n < BOUND) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(bus.b_valid), 32'd1);
      check({tag, "_id"},    32'(bus.b_id),    32'(exp_id));
      check({tag, "_resp"},  32'(bus.b_resp),  32'(exp_resp));
      bus.b_ready = 1'b1;
      tick();
      bus.b_ready = 1'b0;
   endtask

   initial begin
      bus.aw_valid = 1'b0;
      bus.aw_id    = '0;
      bus.aw_len   = '0;
      bus.w_valid  = 1'b0;
      bus.w_last   = 1'b0;
      bus.b_ready  = 1'b0;

      // ---------------- reset values ----------------
      repeat (3) tick();
      check("rst_aw_ready",  32'(bus.aw_ready),        32'd1);
      check("rst_w_ready",   32'(bus.w_ready),         32'd0);
      check("rst_b_valid",   32'(bus.b_valid),         32'd0);
      check("rst_b_id",      32'(bus.b_id),            32'd0);
      check("rst_b_resp",    32'(bus.b_resp),          32'd0);
      check("rst_count",     32'(outstanding_count),   32'd0);
      check("rst_wlast_err", 32'(wlast_err),           32'd0);
      aresetn = 1'b1;
      tick();

      // ---------------- single write, id 3, len 3 ----------------
      bus.aw_valid = 1'b1;
      bus.aw_id    = 4'd3;
      bus.aw_len   = 8'd3;
      tick();
      bus.aw_valid = 1'b0;
      check("single_w_ready_rise", 32'(bus.w_ready),       32'd1);
      check("single_count_1",      32'(outstanding_count), 32'd1);
      for (int b = 0; b < 4; b++) begin
         bus.w_valid = 1'b1;
         bus.w_last  = (b == 3);
         tick();
      end
      bus.w_valid = 1'b0;
      bus.w_last  = 1'b0;
      check("single_b_valid_n1",   32'(bus.b_valid), 32'd0);
      check("single_no_wlast_err", 32'(wlast_err),   32'd0);
      check("single_w_ready_low",  32'(bus.w_ready), 32'd0);
      tick();
      check("single_b_valid_n2",   32'(bus.b_valid),       32'd1);
      check("single_b_id",         32'(bus.b_id),          32'd3);
      check("single_b_resp",       32'(bus.b_resp),        32'd0);
      tick();
      check("single_b_hold",       32'(bus.b_valid),       32'd1);
      bus.b_ready = 1'b1;
      tick();
      bus.b_ready = 1'b0;
      check("single_b_done",       32'(bus.b_valid),       32'd0);
      check("single_count_0",      32'(outstanding_count), 32'd0);

      // ---------------- fill all 16 slots, b_ready low ----------------
      cfg_out_of_order = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         send_aw(ID_WIDTH'(i), 8'd0);
         send_w(1'b1);
      end
      tick();
      check("full_aw_ready",  32'(bus.aw_ready),       32'd0);
      check("full_count",     32'(outstanding_count), 32'd16);
      take_b("full_b0", 4'd0, 2'b00);
      check("full_aw_ready_back", 32'(bus.aw_ready),       32'd1);
      check("full_count_15",      32'(outstanding_count), 32'd15);
      for (int i = 1; i < DEPTH; i++) begin
         take_b("full_drain", ID_WIDTH'(i), 2'b00);
      end
      check("full_count_0", 32'(outstanding_count), 32'd0);

      // ---------------- out of order: id 1 len 7, id 2 len 0 ----------------
      cfg_out_of_order = 1'b1;
      send_aw(4'd1, 8'd7);
      send_aw(4'd2, 8'd0);
      for (int b = 0; b < 8; b++) send_w(b == 7);
      send_w(1'b1);
      repeat (2) tick();
      take_b("ooo_a_first",  4'd1, 2'b00);
      take_b("ooo_a_second", 4'd2, 2'b00);

      // IDs 2,1,2: second id-2 response must follow the first
      send_aw(4'd2, 8'd0);
      send_aw(4'd1, 8'd0);
      send_aw(4'd2, 8'd0);
      repeat (3) send_w(1'b1);
      repeat (2) tick();
      take_b("ooo_b_0", 4'd2, 2'b00);
      take_b("ooo_b_1", 4'd1, 2'b00);
      take_b("ooo_b_2", 4'd2, 2'b00);

      // IDs 2,2,1: the younger id-2 is held behind the older one, id 1 overtakes
      send_aw(4'd2, 8'd0);
      send_aw(4'd2, 8'd0);
      send_aw(4'd1, 8'd0);
      repeat (3) send_w(1'b1);
      repeat (2) tick();
      take_b("ooo_c_0", 4'd2, 2'b00);
      take_b("ooo_c_1", 4'd1, 2'b00);
      take_b("ooo_c_2", 4'd2, 2'b00);
      check("ooo_count_0", 32'(outstanding_count), 32'd0);

      // ---------------- in order, same stimulus ----------------
      cfg_out_of_order = 1'b0;
      send_aw(4'd1, 8'd7);
      send_aw(4'd2, 8'd0);
      for (int b = 0; b < 8; b++) send_w(b == 7);
      send_w(1'b1);
      repeat (2) tick();
      take_b("ino_a_first",  4'd1, 2'b00);
      take_b("ino_a_second", 4'd2, 2'b00);

      send_aw(4'd2, 8'd0);
      send_aw(4'd2, 8'd0);
      send_aw(4'd1, 8'd0);
      repeat (3) send_w(1'b1);
      repeat (2) tick();
      take_b("ino_c_0", 4'd2, 2'b00);
      take_b("ino_c_1", 4'd2, 2'b00);
      take_b("ino_c_2", 4'd1, 2'b00);

      // ---------------- early WLAST: len 3, w_last on beat 2 ----------------
      send_aw(4'd5, 8'd3);
      send_aw(4'd6, 8'd0);
      send_w(1'b0);
      check("wl_beat1_no_err", 32'(wlast_err), 32'd0);
      send_w(1'b1);
      check("wl_pulse",        32'(wlast_err), 32'(ERR_PULSE));
      check("wl_count_2",      32'(outstanding_count), 32'd2);
      tick();
      check("wl_pulse_end",    32'(wlast_err), 32'd0);
      send_w(1'b1);
      check("wl_next_no_err",  32'(wlast_err), 32'd0);
      take_b("wl_err_b", 4'd5, ERR_RESP);
      take_b("wl_ok_b",  4'd6, 2'b00);

      // ---------------- reset with 5 outstanding and b_valid high -----------
      for (int i = 0; i < 5; i++) begin
         send_aw(ID_WIDTH'(i + 8), 8'd0);
         send_w(1'b1);
      end
      repeat (2) tick();
      check("pre_rst_b_valid", 32'(bus.b_valid),       32'd1);
      check("pre_rst_count",   32'(outstanding_count), 32'd5);
      aresetn = 1'b0;
      tick();
      check("mid_rst_b_valid",  32'(bus.b_valid),       32'd0);
      check("mid_rst_count",    32'(outstanding_count), 32'd0);
      check("mid_rst_aw_ready", 32'(bus.aw_ready),      32'd1);
      check("mid_rst_w_ready",  32'(bus.w_ready),       32'd0);
      aresetn = 1'b1;
      repeat (4) tick();
      check("post_rst_no_b", 32'(bus.b_valid), 32'd0);

      // fresh write after reset
      send_aw(4'd9, 8'd1);
      send_w(1'b0);
      send_w(1'b1);
      take_b("post_rst_b", 4'd9, 2'b00);
      check("post_rst_count_0", 32'(outstanding_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
